// File: rtl/branch_cmp_iter.sv
// Multi-cycle branch comparator, CHUNK bits per cycle, MSB chunk first.
// Optional macro CMP_EARLY_EXIT_EN: finish as soon as the first chunk differs.
module branch_cmp_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       cmpop,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             br_en,
  output logic             illegal_op
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("branch_cmp_iter: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             ill_q, ill_d;

  logic [CHUNK-1:0] a_c, b_c;
  logic [WIDTH-1:0] flip;
  logic             eq_n, lt_n;
  logic             last;

  assign a_c  = a_q[WIDTH-1 -: CHUNK];
  assign b_c  = b_q[WIDTH-1 -: CHUNK];
  assign eq_n = eq_q & (a_c == b_c);
  assign lt_n = lt_q | (eq_q & (a_c < b_c));
  // Flipping the sign bit of both operands turns signed order into unsigned.
  assign flip = {(cmpop[2:1] == 2'b10), {(WIDTH-1){1'b0}}};

  function automatic logic result(input logic [2:0] op,
                                  input logic eq, input logic lt);
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (op[2:1] == 2'b00): r = op[0] ? !eq : eq;
      (op[2]):            r = op[0] ? !lt : lt;
      default:            r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    ill_d   = ill_q;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d  = cmpop;
          a_d   = rs1 ^ flip;
          b_d   = rs2 ^ flip;
          eq_d  = 1'b1;
          lt_d  = 1'b0;
          cnt_d = CW'(NCHUNK - 1);
          if (cmpop[2:1] == 2'b01) begin
            state_d = DONE;
            ill_d   = 1'b1;
            br_d    = 1'b0;
          end else begin
            state_d = BUSY;
            ill_d   = 1'b0;
          end
        end
      end
      BUSY: begin
        eq_d = eq_n;
        lt_d = lt_n;
        a_d  = a_q << CHUNK;
        b_d  = b_q << CHUNK;
        last = (cnt_q == '0);
`ifdef CMP_EARLY_EXIT_EN
        if (eq_q && !eq_n) last = 1'b1;
`endif
        if (last) begin
          state_d = DONE;
          br_d    = result(op_q, eq_n, lt_n);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      ill_q   <= ill_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign br_en      = br_q;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_branch_cmp_iter.sv
// Scoreboard bench for branch_cmp_iter (default WIDTH=32, CHUNK=8).
// Latency is counted in posedges after the accepting edge.
module tb_branch_cmp_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  cmpop;
  logic [31:0] rs1, rs2;
  logic        resp_valid;
  logic        resp_ready;
  logic        br_en;
  logic        illegal_op;

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic  br;
    logic  ill;
    int    lat;
    string tag;
  } exp_t;

  exp_t sb[$];

  branch_cmp_iter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .cmpop      (cmpop),
    .rs1        (rs1),
    .rs2        (rs2),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .br_en      (br_en),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_br(input logic [2:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    case (op)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    if (op == 3'b010 || op == 3'b011) return 0;
`ifdef CMP_EARLY_EXIT_EN
    for (int i = 0; i < 4; i++)
      if (a[31-8*i -: 8] != b[31-8*i -: 8]) return i + 1;
`endif
    return 4;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk({tag, "_ready_to"}, req_ready, 1);
  endtask

  // Drive one request; expected result is queued at issue time.
  task automatic issue(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.br  = model_br(op, a, b);
    e.ill = (op == 3'b010 || op == 3'b011);
    e.lat = model_lat(op, a, b);
    e.tag = tag;
    wait_ready(tag);
    sb.push_back(e);
    req_valid = 1'b1;
    cmpop = op;
    rs1 = a;
    rs2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cmpop = 3'($urandom);
    rs1 = $urandom;
    rs2 = $urandom;
  endtask

  task automatic collect();
    exp_t e;
    int lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    if (!resp_valid) begin
      chk({e.tag, "_resp_to"}, resp_valid, 1);
      return;
    end
    chk({e.tag, "_br"}, br_en, e.br);
    chk({e.tag, "_ill"}, illegal_op, e.ill);
    chk({e.tag, "_lat"}, lat, e.lat);
  endtask

  task automatic run(input string tag, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b);
    issue(tag, op, a, b);
    collect();
  endtask

  initial begin
    logic [2:0]  ops [8];
    logic [31:0] a, b;
    int seen;
    ops = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
    rst = 1'b1;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    cmpop = 3'b000;
    rs1 = '0;
    rs2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_rvalid", resp_valid, 0);
    chk("rst_br", br_en, 0);
    chk("rst_ill", illegal_op, 0);

    run("beq_eq", 3'b000, 32'h12345678, 32'h12345678);
    run("blt_neg", 3'b100, 32'hFFFFFFFF, 32'h00000001);
    run("bltu_big", 3'b110, 32'hFFFFFFFF, 32'h00000001);
    run("bge_eq", 3'b101, 32'h80000000, 32'h80000000);
    run("bgeu_msb", 3'b111, 32'h7FFFFFFF, 32'h80000000);
    run("ill_010", 3'b010, 32'h1, 32'h1);
    run("ill_011", 3'b011, 32'h5, 32'h3);
    run("bne_top", 3'b001, 32'h01000000, 32'h00000000);
    run("bne_low", 3'b001, 32'h00000001, 32'h00000000);
    run("blt_low", 3'b100, 32'h00000100, 32'h00000101);
    run("bgeu_eq", 3'b111, 32'hDEADBEEF, 32'hDEADBEEF);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = a;
      b[8*$urandom_range(0, 3) +: 8] = 8'($urandom);
      if (i % 5 == 0) b = $urandom;
      run("rnd", ops[$urandom_range(0, 7)], a, b);
    end

    // Consumer stalls: outputs must hold while resp_ready is low.
    wait_ready("hold");
    resp_ready = 1'b0;
    issue("hold", 3'b101, 32'h80000000, 32'h80000000);
    collect();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_rvalid", resp_valid, 1);
      chk("hold_br", br_en, 1);
      chk("hold_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", req_ready, 1);
    chk("release_rvalid", resp_valid, 0);

    // Reset while busy discards the pending compare.
    wait_ready("abort");
    req_valid = 1'b1;
    cmpop = 3'b000;
    rs1 = 32'hA5A5A5A5;
    rs2 = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", req_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", req_ready, 1);
    chk("abort_rvalid", resp_valid, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    chk("abort_noresp", seen, 0);

    run("post_abort", 3'b110, 32'h00000001, 32'hFFFFFFFF);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
